// File: rtl/network_sequencer.sv
// Control-path sequencer for a chain of dense layers: starts each layer in turn,
// waits for its done level, guards every wait with a timeout and reports latency.
module network_sequencer #(
  parameter int  NUM_LAYERS     = 3,
  parameter int  TIMEOUT_CYCLES = 4096,
  parameter int  COUNT_WIDTH    = 32,
  localparam int LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_LAYERS-1:0]  layer_start,
  input  logic [NUM_LAYERS-1:0]  layer_done,
  output logic [LAYER_W-1:0]     active_layer,
  output logic                   busy,
  output logic                   error,
  input  logic                   error_clear,
  output logic [COUNT_WIDTH-1:0] latency
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_OUTPUT = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [LAYER_W-1:0]       layer_idx;
  logic                     armed;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [COUNT_WIDTH-1:0]   lat_cnt;
  logic                     done_cur;
  logic                     complete;
  logic                     timed_out;

  // Latency counter stops at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A done level left high by the previous run must be seen low once before it counts.
  assign done_cur  = layer_done[layer_idx];
  assign complete  = armed && done_cur;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection; completion takes priority over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid && in_ready) state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (complete)       state_nxt = (layer_idx == LAST_LAYER) ? S_OUTPUT : S_START;
        else if (timed_out) state_nxt = S_ERROR;
      end
      S_OUTPUT: if (out_ready) state_nxt = S_IDLE;
      S_ERROR:  if (error_clear) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    layer_start = '0;
    if (state == S_START) layer_start[layer_idx] = 1'b1;
    out_valid    = (state == S_OUTPUT);
    busy         = (state == S_START) || (state == S_WAIT);
    error        = (state == S_ERROR);
    active_layer = layer_idx;
  end

  // Layer index, arming, per-layer wait count, latency and the registered in_ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      layer_idx <= '0;
      armed     <= 1'b0;
      wait_cnt  <= '0;
      lat_cnt   <= '0;
      latency   <= '0;
    end else begin
      in_ready <= (state_nxt == S_IDLE);
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            layer_idx <= '0;
            lat_cnt   <= '0;
          end
        end
        S_START: begin
          armed    <= 1'b0;
          wait_cnt <= '0;
          lat_cnt  <= sat_inc(lat_cnt);
        end
        S_WAIT: begin
          lat_cnt  <= sat_inc(lat_cnt);
          wait_cnt <= wait_cnt + 1'b1;
          if (!done_cur) armed <= 1'b1;
          if (complete) begin
            if (layer_idx == LAST_LAYER) latency   <= sat_inc(lat_cnt);
            else                         layer_idx <= layer_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_network_sequencer.sv
// Randomized bench for network_sequencer: a reactive layer environment plus a
// timing model computed from per-layer done delays.
module tb_network_sequencer;

  localparam int NL      = 3;
  localparam int TO      = 16;
  localparam int CW      = 5;
  localparam int LAT_MAX = (1 << CW) - 1;
  localparam int LW      = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done = '1;
  logic [LW-1:0] active_layer;
  logic          busy;
  logic          error;
  logic          error_clear = 1'b0;
  logic [CW-1:0] latency;

  network_sequencer #(
    .NUM_LAYERS     (NL),
    .TIMEOUT_CYCLES (TO),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .layer_start  (layer_start),
    .layer_done   (layer_done),
    .active_layer (active_layer),
    .busy         (busy),
    .error        (error),
    .error_clear  (error_clear),
    .latency      (latency)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int last_lat = 0;
  int dly [NL];
  int drp [NL];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_layers(input int d0, input int d1, input int d2,
                            input int p0, input int p1, input int p2);
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    drp[0] = p0; drp[1] = p1; drp[2] = p2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    last_lat = 0;
  endtask

  // One inference: the model predicts each start cycle, the outcome cycle,
  // the failing layer (if any) and the saturated latency.
  task automatic run_inf(input bit noise, input int hold, input int abort_at);
    int  exp_start [NL];
    int  st [NL];
    int  tot, err_layer, err_cyc_exp, exp_lat, npulse, c, k, act;
    bit  ok, got_out, got_err, aborted;

    tot = 0; err_layer = -1; err_cyc_exp = 0;
    for (int j = 0; j < NL; j++) begin
      exp_start[j] = tot;
      st[j] = -1000;
      if (err_layer < 0) begin
        if (dly[j] > TO) begin
          err_layer   = j;
          err_cyc_exp = tot + TO + 1;
        end else begin
          tot += dly[j] + 1;
        end
      end
    end
    exp_lat = (tot > LAT_MAX) ? LAT_MAX : tot;

    ok = 1'b0;
    for (int w = 0; w < 8 && !ok; w++) begin
      if (in_ready) ok = 1'b1;
      else @(negedge clock);
    end
    check("req_ready", int'(ok), 1);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;

    c = 0; act = -1; npulse = 0;
    got_out = 1'b0; got_err = 1'b0; aborted = 1'b0;
    while (c < 200) begin
      if (c == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (layer_start != '0) begin
        k = 0;
        for (int j = NL - 1; j >= 0; j--) if (layer_start[j]) k = j;
        check("start_onehot", $countones(layer_start), 1);
        check("start_layer", k, npulse);
        check("start_cycle", c, exp_start[k]);
        check("start_active", int'(active_layer), k);
        check("start_busy", int'(busy), 1);
        npulse++;
        act = k;
        st[k] = c;
      end
      if (out_valid) begin got_out = 1'b1; break; end
      if (error)     begin got_err = 1'b1; break; end
      error_clear = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      for (int j = 0; j < NL; j++) begin
        if (j == act) begin
          if (c == st[j] + drp[j]) layer_done[j] = 1'b0;
          if (c == st[j] + dly[j]) layer_done[j] = 1'b1;
        end else if (noise) begin
          layer_done[j] = 1'($urandom_range(1, 0));
        end
      end
      @(negedge clock);
      c++;
    end
    error_clear = 1'b0;

    if (aborted) begin
      reset = 1'b0;
      @(negedge clock);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_start", int'(layer_start), 0);
      check("rst_active", int'(active_layer), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_error", int'(error), 0);
      check("rst_latency", int'(latency), 0);
      @(negedge clock);
      check("rst_hold_start", int'(layer_start), 0);
      check("rst_hold_ready", int'(in_ready), 0);
      reset = 1'b1;
      @(negedge clock);
      check("rst_release_ready", int'(in_ready), 1);
      last_lat = 0;
    end else if (err_layer >= 0) begin
      check("err_seen", int'(got_err), 1);
      check("err_cycle", c, err_cyc_exp);
      check("err_layer", int'(active_layer), err_layer);
      check("err_pulses", npulse, err_layer + 1);
      check("err_out_valid", int'(out_valid), 0);
      check("err_in_ready", int'(in_ready), 0);
      check("err_busy", int'(busy), 0);
      check("err_latency", int'(latency), last_lat);
      in_valid = 1'b1;
      repeat (2) begin
        @(negedge clock);
        check("err_sticky", int'(error), 1);
        check("err_no_accept", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      error_clear = 1'b1;
      @(negedge clock);
      error_clear = 1'b0;
      check("clr_error", int'(error), 0);
      check("clr_in_ready", int'(in_ready), 1);
      if (!got_err) do_reset();
    end else begin
      check("out_seen", int'(got_out), 1);
      check("out_cycle", c, tot);
      check("out_pulses", npulse, NL);
      check("out_latency", int'(latency), exp_lat);
      check("out_busy", int'(busy), 0);
      check("out_in_ready", int'(in_ready), 0);
      check("out_error", int'(error), 0);
      in_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_in_ready", int'(in_ready), 0);
        check("hold_busy", int'(busy), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check("done_out_valid", int'(out_valid), 0);
      check("done_in_ready", int'(in_ready), 1);
      last_lat = exp_lat;
      if (!got_out) do_reset();
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_start", int'(layer_start), 0);
    check("reset_active", int'(active_layer), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_error", int'(error), 0);
    check("reset_latency", int'(latency), 0);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_ready", int'(in_ready), 1);

    // Done held high since reset: never armed, times out on layer 0.
    set_layers(1000, 1000, 1000, 1000, 1000, 1000);
    run_inf(1'b0, 0, -1);
    // Each layer done five cycles after its start.
    set_layers(5, 5, 5, 0, 0, 0);
    run_inf(1'b0, 0, -1);
    // Host stalls the result for ten cycles.
    set_layers(3, 2, 4, 1, 0, 2);
    run_inf(1'b0, 10, -1);
    // Other layers' done bits toggling while one layer is awaited.
    set_layers(6, 6, 6, 0, 3, 5);
    run_inf(1'b1, 1, -1);
    // Completion on the last allowed wait cycle; latency saturates.
    set_layers(TO, TO, 2, TO - 1, 0, 1);
    run_inf(1'b0, 0, -1);
    // One cycle too slow on layer 1.
    set_layers(2, TO + 1, 2, 0, 0, 0);
    run_inf(1'b0, 0, -1);
    // Reset while waiting on layer 1.
    set_layers(4, 12, 12, 0, 0, 0);
    run_inf(1'b0, 0, 8);

    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < NL; j++) begin
        dly[j] = int'($urandom_range(TO + 2, 2));
        drp[j] = int'($urandom_range(32'(dly[j] - 1), 0));
      end
      run_inf(1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
              (i % 10 == 9) ? int'($urandom_range(20, 1)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
